// File: rtl/seg_dec_pkg.sv
// Shared types and constants for the 7-segment scan decoder.
//   - SEG_0..SEG_9, SEG_BLANK : active-low segment patterns, seg[0]=a .. seg[6]=g
//   - state_e                 : dwell qualification FSM states
//   - bcd_t / seg_dec_t       : decoded digit payload
//   - bcd_to_bin              : four BCD digits to a 14-bit binary value
package seg_dec_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned AN_W    = 4;
  localparam int unsigned BCD_W   = 4;
  localparam int unsigned FRAME_W = AN_W * BCD_W;
  localparam int unsigned VALUE_W = 14;
  localparam int unsigned OVR_W   = 8;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

  typedef struct packed {
    bcd_t digit;
    logic blank;
    logic err;
  } seg_dec_t;

  // {d3,d2,d1,d0} -> d3*1000 + d2*100 + d1*10 + d0; 9999 fits in 14 bits
  function automatic logic [VALUE_W-1:0] bcd_to_bin(input logic [FRAME_W-1:0] bcd);
    bcd_to_bin = VALUE_W'(bcd[15:12]) * VALUE_W'(1000)
               + VALUE_W'(bcd[11:8])  * VALUE_W'(100)
               + VALUE_W'(bcd[7:4])   * VALUE_W'(10)
               + VALUE_W'(bcd[3:0]);
  endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7_decode.sv
// Combinational 7-segment pattern decoder.
//   seg   : active-low segment lines
//   dec_c : {digit, blank, err}; blank and undecodable patterns read as digit 0
module seg7_decode
  import seg_dec_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output seg_dec_t         dec_c
);

  always_comb begin
    dec_c.digit = '0;
    dec_c.blank = 1'b0;
    dec_c.err   = 1'b0;
    case (seg)
      SEG_0:     dec_c.digit = 4'd0;
      SEG_1:     dec_c.digit = 4'd1;
      SEG_2:     dec_c.digit = 4'd2;
      SEG_3:     dec_c.digit = 4'd3;
      SEG_4:     dec_c.digit = 4'd4;
      SEG_5:     dec_c.digit = 4'd5;
      SEG_6:     dec_c.digit = 4'd6;
      SEG_7:     dec_c.digit = 4'd7;
      SEG_8:     dec_c.digit = 4'd8;
      SEG_9:     dec_c.digit = 4'd9;
      SEG_BLANK: dec_c.blank = 1'b1;
      default:   dec_c.err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side 7-segment scan decoder: qualifies each anode dwell, decodes the
// sampled pattern, assembles four digits into a frame and offers it on a
// one-deep valid/ready output.
//   Parameter SETTLE_CYCLES : stable cycles of an_r before seg_r is sampled (1..255)
//   clk, rst_n              : clock, synchronous active-low reset
//   seg, an                 : multiplexed display bus (both active-low)
//   frame_bcd/blank/err     : assembled frame contents
//   frame_value             : binary value of the frame (0 unless SEG_DEC_BIN_EN)
//   frame_valid/ready       : output handshake
//   overrun_cnt             : saturating count of frames dropped while output stalled
// Build option: define SEG_DEC_BIN_EN to build the BCD->binary converter.
module seg_scan_decoder
  import seg_dec_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SEG_W-1:0]     seg,
  input  logic [AN_W-1:0]      an,
  output logic [FRAME_W-1:0]   frame_bcd,
  output logic [AN_W-1:0]      frame_blank,
  output logic                 frame_err,
  output logic [VALUE_W-1:0]   frame_value,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic [OVR_W-1:0]     overrun_cnt
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

  logic [SEG_W-1:0]   seg_r_q;
  logic [AN_W-1:0]    an_r_q, an_p_q;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AN_W-1:0]    mask_q, mask_d;
  logic [FRAME_W-1:0] acc_bcd_q, acc_bcd_d;
  logic [AN_W-1:0]    acc_blank_q, acc_blank_d;
  logic [AN_W-1:0]    acc_err_q, acc_err_d;
  logic [FRAME_W-1:0] frame_bcd_q, frame_bcd_d;
  logic [AN_W-1:0]    frame_blank_q, frame_blank_d;
  logic               frame_err_q, frame_err_d;
  logic [VALUE_W-1:0] frame_value_q, frame_value_d;
  logic               frame_valid_q, frame_valid_d;
  logic [OVR_W-1:0]   overrun_q, overrun_d;

  logic               an_valid_c, an_chg_c, sample_c, complete_c;
  logic [1:0]         slot_c;
  logic [AN_W-1:0]    mask_new_c;
  seg_dec_t           dec_c;

  seg7_decode u_dec (.seg(seg_r_q), .dec_c(dec_c));

  // Anode qualification: exactly one low bit selects a slot
  always_comb begin
    an_valid_c = 1'b1;
    slot_c     = 2'd0;
    case (an_r_q)
      4'b1110: slot_c = 2'd0;
      4'b1101: slot_c = 2'd1;
      4'b1011: slot_c = 2'd2;
      4'b0111: slot_c = 2'd3;
      default: an_valid_c = 1'b0;
    endcase
    an_chg_c = (an_r_q != an_p_q);
  end

  // Dwell FSM: one sample per dwell once an_r has been stable long enough
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sample_c = 1'b0;
    if (an_chg_c) begin
      if (an_valid_c) begin
        state_d = S_SETTLE;
        cnt_d   = CNT_W'(1);
        if (SETTLE_CYCLES == 1) begin
          sample_c = 1'b1;
          state_d  = S_HOLD;
        end
      end else begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        S_SETTLE: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(SETTLE_CYCLES)) begin
            sample_c = 1'b1;
            state_d  = S_HOLD;
          end
        end
        S_HOLD:  cnt_d = cnt_q;
        default: cnt_d = '0;
      endcase
    end
  end

  // Frame assembly and one-deep output register
  always_comb begin
    acc_bcd_d     = acc_bcd_q;
    acc_blank_d   = acc_blank_q;
    acc_err_d     = acc_err_q;
    frame_bcd_d   = frame_bcd_q;
    frame_blank_d = frame_blank_q;
    frame_err_d   = frame_err_q;
    frame_value_d = frame_value_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = overrun_q;
    mask_new_c    = mask_q;

    for (int i = 0; i < int'(AN_W); i++) begin
      if (sample_c && (slot_c == 2'(i))) begin
        acc_bcd_d[4*i +: 4] = dec_c.digit;
        acc_blank_d[i]      = dec_c.blank;
        acc_err_d[i]        = dec_c.err;
        mask_new_c[i]       = 1'b1;
      end
    end

    complete_c = sample_c && (mask_new_c == 4'hF);
    mask_d     = complete_c ? '0 : mask_new_c;

    if (complete_c) begin
      if (!frame_valid_q || frame_ready) begin
        frame_bcd_d   = acc_bcd_d;
        frame_blank_d = acc_blank_d;
        frame_err_d   = |acc_err_d;
`ifdef SEG_DEC_BIN_EN
        frame_value_d = bcd_to_bin(acc_bcd_d);
`else
        frame_value_d = '0;
`endif
        frame_valid_d = 1'b1;
      end else if (overrun_q != '1) begin
        overrun_d = overrun_q + OVR_W'(1);
      end
    end else if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_r_q       <= SEG_BLANK;
      an_r_q        <= 4'hF;
      an_p_q        <= 4'hF;
      state_q       <= S_WAIT;
      cnt_q         <= '0;
      mask_q        <= '0;
      acc_bcd_q     <= '0;
      acc_blank_q   <= '0;
      acc_err_q     <= '0;
      frame_bcd_q   <= '0;
      frame_blank_q <= '0;
      frame_err_q   <= 1'b0;
      frame_value_q <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= '0;
    end else begin
      seg_r_q       <= seg;
      an_r_q        <= an;
      an_p_q        <= an_r_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      acc_bcd_q     <= acc_bcd_d;
      acc_blank_q   <= acc_blank_d;
      acc_err_q     <= acc_err_d;
      frame_bcd_q   <= frame_bcd_d;
      frame_blank_q <= frame_blank_d;
      frame_err_q   <= frame_err_d;
      frame_value_q <= frame_value_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign frame_bcd   = frame_bcd_q;
  assign frame_blank = frame_blank_q;
  assign frame_err   = frame_err_q;
  assign frame_value = frame_value_q;
  assign frame_valid = frame_valid_q;
  assign overrun_cnt = overrun_q;

endmodule
